// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: shares one W-bit bidirectional GPIO bus among N requesters.
// Each grant runs one single-beat transaction. Arbitration is round-robin.
// Turnaround cycles are inserted whenever the bus direction changes.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req/wr/wdata        per-requester request level, direction (1=write), write data
//   gnt/done            one-hot grant (selection..DONE), one-cycle completion pulse
//   rdata               data captured by the last completed read
//   gpio_in             pin values fed back from the top-level tristate
//   gpio_out/gpio_oe    pin drive value and per-pin output enable
//   gpio_stb/gpio_dir   strobe and direction seen by the external device
module gpio_bus_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned TURN    = 2,
    parameter int unsigned STB_CYC = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   wr,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic [W-1:0]   rdata,
    input  logic [W-1:0]   gpio_in,
    output logic [W-1:0]   gpio_out,
    output logic [W-1:0]   gpio_oe,
    output logic           gpio_stb,
    output logic           gpio_dir
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TURN,
        S_XFER,
        S_DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic          last_dir;
    logic          last_dir_valid;
    logic          cur_dir;
    logic [W-1:0]  cur_data;
    logic [CW-1:0] cnt;

    logic          win_found_c;
    logic [IW-1:0] win_idx_c;
    logic          win_wr_c;
    logic [W-1:0]  win_data_c;
    logic [IW:0]   sum_c;
    logic [IW-1:0] idx_c;

    // Round-robin pick: first set req bit at or above rr_ptr, wrapping modulo N.
    // Scanning from the far end down lets the closest candidate overwrite the rest.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        sum_c       = '0;
        idx_c       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum_c = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum_c >= (IW+1)'(N)) begin
                sum_c = sum_c - (IW+1)'(N);
            end
            idx_c = sum_c[IW-1:0];
            if (req[idx_c]) begin
                win_found_c = 1'b1;
                win_idx_c   = idx_c;
            end
        end
    end

    // Select the winner's direction and write data.
    always_comb begin
        win_wr_c   = 1'b0;
        win_data_c = '0;
        for (int i = 0; i < N; i++) begin
            if (win_idx_c == IW'(i)) begin
                win_wr_c   = wr[i];
                win_data_c = wdata[i*W +: W];
            end
        end
    end

    // Transaction FSM; every output is a register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            last_dir       <= 1'b0;
            last_dir_valid <= 1'b0;
            cur_dir        <= 1'b0;
            cur_data       <= '0;
            cnt            <= '0;
            gnt            <= '0;
            done           <= '0;
            rdata          <= '0;
            gpio_out       <= '0;
            gpio_oe        <= '0;
            gpio_stb       <= 1'b0;
            gpio_dir       <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    gnt      <= '0;
                    gpio_oe  <= '0;
                    gpio_stb <= 1'b0;
                    if (win_found_c) begin
                        owner    <= win_idx_c;
                        cur_dir  <= win_wr_c;
                        cur_data <= win_data_c;
                        gnt      <= N'(1) << win_idx_c;
                        gpio_dir <= win_wr_c;
                        // Unknown or changed direction: release the bus first.
                        if (!last_dir_valid || (win_wr_c != last_dir)) begin
                            state <= S_TURN;
                            cnt   <= CW'(TURN);
                        end else begin
                            state    <= S_XFER;
                            cnt      <= CW'(STB_CYC);
                            gpio_stb <= 1'b1;
                            gpio_oe  <= {W{win_wr_c}};
                            if (win_wr_c) begin
                                gpio_out <= win_data_c;
                            end
                        end
                    end
                end
                S_TURN: begin
                    if (cnt == CW'(1)) begin
                        state    <= S_XFER;
                        cnt      <= CW'(STB_CYC);
                        gpio_stb <= 1'b1;
                        gpio_oe  <= {W{cur_dir}};
                        if (cur_dir) begin
                            gpio_out <= cur_data;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_XFER: begin
                    if (cnt == CW'(1)) begin
                        state    <= S_DONE;
                        gpio_stb <= 1'b0;
                        done     <= gnt;
                        if (!cur_dir) begin
                            rdata <= gpio_in;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    // Write data stays driven through DONE for hold time.
                    state          <= S_IDLE;
                    gnt            <= '0;
                    gpio_oe        <= '0;
                    last_dir       <= cur_dir;
                    last_dir_valid <= 1'b1;
                    rr_ptr         <= (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter: randomized and directed stimulus for gpio_bus_arbiter,
// checked every cycle against a transaction-level schedule model.
module tb_gpio_bus_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int TURN = 2;
    localparam int STB  = 2;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req     = '0;
    logic [N-1:0]   wr      = '0;
    logic [N*W-1:0] wdata   = '0;
    logic [W-1:0]   gpio_in = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   rdata;
    logic [W-1:0]   gpio_out;
    logic [W-1:0]   gpio_oe;
    logic           gpio_stb;
    logic           gpio_dir;

    gpio_bus_arbiter #(.N(N), .W(W), .TURN(TURN), .STB_CYC(STB)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .wr       (wr),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .rdata    (rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .gpio_stb (gpio_stb),
        .gpio_dir (gpio_dir)
    );

    always #5 clk = ~clk;

    int n_err  = 0;
    int n_chk  = 0;
    int edge_n = 0;

    // Reference: one active transaction described by its grant edge and length.
    bit         busy;
    int         e0;
    int         own;
    int         trn;
    int         len;
    bit         dir_t;
    logic [7:0] data_t;
    int         rr;
    bit         ld_known;
    bit         ld;

    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_done;
    logic [W-1:0] exp_oe;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_rdata;
    logic         exp_stb;
    logic         exp_dir;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic check_all();
        check("gnt",   32'(gnt),      32'(exp_gnt));
        check("done",  32'(done),     32'(exp_done));
        check("oe",    32'(gpio_oe),  32'(exp_oe));
        check("stb",   32'(gpio_stb), 32'(exp_stb));
        check("dir",   32'(gpio_dir), 32'(exp_dir));
        check("out",   32'(gpio_out), 32'(exp_out));
        check("rdata", 32'(rdata),    32'(exp_rdata));
    endtask

    task automatic model_reset();
        busy      = 1'b0;
        rr        = 0;
        ld_known  = 1'b0;
        ld        = 1'b0;
        exp_gnt   = '0;
        exp_done  = '0;
        exp_oe    = '0;
        exp_out   = '0;
        exp_rdata = '0;
        exp_stb   = 1'b0;
        exp_dir   = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then check.
    task automatic step();
        int k;
        logic [N-1:0] r;
        @(posedge clk);
        edge_n++;
        r = req;
        if (busy) begin
            k = edge_n - e0;
            if (k == len && !dir_t) exp_rdata = gpio_in;
            if (k >= len + 2) busy = 1'b0;
        end
        if (!busy && r != '0) begin
            own = -1;
            for (int j = 0; j < N; j++) begin
                if (own < 0 && r[(rr + j) % N]) own = (rr + j) % N;
            end
            dir_t    = wr[own];
            data_t   = wdata[own*W +: W];
            trn      = (!ld_known || ld != dir_t) ? TURN : 0;
            len      = trn + STB;
            e0       = edge_n;
            busy     = 1'b1;
            rr       = (own + 1) % N;
            ld       = dir_t;
            ld_known = 1'b1;
            exp_dir  = dir_t;
        end
        exp_gnt  = '0;
        exp_done = '0;
        exp_oe   = '0;
        exp_stb  = 1'b0;
        if (busy) begin
            k = edge_n - e0;
            if (k <= len) begin
                exp_gnt  = N'(1) << own;
                exp_stb  = (k >= trn) && (k < len);
                exp_oe   = (dir_t && k >= trn) ? '1 : '0;
                exp_done = (k == len) ? exp_gnt : '0;
                if (dir_t && k == trn) exp_out = data_t;
            end
        end
        #1;
        check_all();
    endtask

    // Asynchronous reset from the middle of a cycle; outputs must clear at once.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic set_req(input int idx, input bit w, input logic [7:0] d);
        req[idx]          = 1'b1;
        wr[idx]           = w;
        wdata[idx*W +: W] = d;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset_n = 1'b1;

        // First write after reset, always with turnaround.
        set_req(0, 1'b1, 8'hA5);
        step();
        req = '0;
        repeat (8) step();

        // Same-direction back-to-back writes from requester 0.
        set_req(0, 1'b1, 8'h11);
        step();
        wdata[0*W +: W] = 8'h22;
        repeat (6) step();
        req = '0;
        repeat (6) step();

        // Read after write on requester 2.
        set_req(2, 1'b0, 8'h00);
        gpio_in = 8'h3C;
        step();
        req = '0;
        repeat (7) step();
        gpio_in = 8'hC3;
        repeat (3) step();

        // Everyone requesting writes continuously.
        req = '1;
        wr  = '1;
        for (int i = 0; i < N; i++) wdata[i*W +: W] = 8'(8'h40 + i);
        repeat (26) step();
        req = '0;
        repeat (6) step();

        // Reset in the XFER phase of a write, then req=0110.
        set_req(0, 1'b1, 8'h5A);
        wr = 4'b0111;
        step();
        req = '0;
        for (int i = 0; i < 10; i++) begin
            if (busy && (edge_n - e0) >= trn) break;
            step();
        end
        do_reset();
        req = 4'b0110;
        repeat (10) step();
        req = '0;
        repeat (6) step();

        // Requester 3 drops its request right after the grant.
        set_req(3, 1'b0, 8'h00);
        gpio_in = 8'h96;
        step();
        req = '0;
        repeat (8) step();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            req     = N'($urandom_range(0, 15));
            wr      = N'($urandom);
            wdata   = (N*W)'($urandom);
            gpio_in = W'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
